binary_to_bcd_seq: RTL

// - Sequential, parametrised binary-to-BCD converter (shift-and-add-3).

---
 rtl/bcd_pkg.sv | 17 +
 rtl/add3.sv | 11 +
 rtl/binary_to_bcd_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_DIGIT_W = 4;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Decimal digits needed to hold any dw-bit unsigned value: ceil(dw*log10(2)).
    // The scaled constant rounds log10(2) up, so the result never undershoots.
    function automatic int unsigned min_digits(input int unsigned dw);
        return (dw * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/add3.sv
// Shift-and-add-3 correction cell: adds 3 to a BCD digit of 5 or more.
module add3
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] bcd_i,
    output logic [BCD_DIGIT_W-1:0] bcd_o
);

    assign bcd_o = (bcd_i >= BCD_DIGIT_W'(5)) ? bcd_i + BCD_DIGIT_W'(3) : bcd_i;

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one column of add3 cells iterated over DW
// cycles, with start/busy/done handshake, optional signed input and overflow flag.
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned DW     = 17,
    parameter int unsigned DIGITS = 5,
    parameter bit          SIGNED = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [DW-1:0]                   bin_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
    output logic                            neg,
    output logic                            overflow
);

    localparam int unsigned BW    = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(DW + 1);
    // With enough digits for any magnitude the carry-out can never fire.
    localparam bit OVF_POSSIBLE = (DIGITS < min_digits(DW));

    generate
        if (DW < 2 || DIGITS < 1) begin : g_param_err
            $error("binary_to_bcd_seq: DW must be >= 2 and DIGITS >= 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [DW-1:0]      sreg_q, sreg_d;
    logic [BW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               sign_q, sign_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BW-1:0]      bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_out_q, ovf_out_d;

    logic [BW-1:0]      acc_adj;
    logic [BW-1:0]      acc_shl;
    logic [DW-1:0]      sreg_shl;
    logic               carry;
    logic               in_neg;
    logic [DW-1:0]      mag;

    // Correction column: one add3 per accumulator digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        add3 u_add3 (
            .bcd_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .bcd_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign {carry, acc_shl, sreg_shl} = {acc_adj, sreg_q, 1'b0};

    // Two's-complement magnitude on DW bits so the most negative value maps to 2^(DW-1).
    assign in_neg = SIGNED && bin_in[DW-1];
    assign mag    = in_neg ? (~bin_in) + DW'(1) : bin_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sign_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sign_q    <= sign_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sign_d    = sign_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_out_d = ovf_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sreg_d  = mag;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CNT_W'(DW);
                    sign_d  = in_neg;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                sreg_d = sreg_shl;
                acc_d  = acc_shl;
                ovf_d  = ovf_q | carry;
                cnt_d  = cnt_q - CNT_W'(1);
                // Last shift: publish the result in the same edge.
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    bcd_d     = acc_shl;
                    neg_d     = sign_q;
                    ovf_out_d = OVF_POSSIBLE & (ovf_q | carry);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign neg      = neg_q;
    assign overflow = ovf_out_q;

endmodule
